// File: rtl/booth_div_pkg.sv
// ---------------------------------------------------------------------------
// booth_div_pkg
// Shared definitions for the sequential signed divider:
//   - controller state encoding (IDLE / CALC / FIX / DONE)
//   - width of the iteration counter, derived from the operand width
//   - quotient pattern forced when the divisor is zero (all ones = -1)
// ---------------------------------------------------------------------------
package booth_div_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_FIX_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

  // Wide enough for any supported WIDTH; users take the low WIDTH bits.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_div_core.sv
// ---------------------------------------------------------------------------
// booth_div_core
// Unsigned non-restoring division step datapath. Holds the signed partial
// remainder (WIDTH+1 bits), the dividend/quotient shift register and the
// step counter. One step is taken per clock while step_i is high.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous reset, active-low
//   load_i         in   load operands and restart the iteration
//   step_i         in   perform one non-restoring step
//   dividend_mag_i in   |dividend| (WIDTH bits, |MIN| fits unsigned)
//   divisor_mag_i  in   |divisor| (WIDTH+1 bits)
//   part_rem_o     out  current partial remainder (signed, WIDTH+1 bits)
//   quo_o          out  quotient magnitude shift register
//   dvs_o          out  latched divisor magnitude
//   last_step_o    out  the step taken on the next edge is the final one
// ---------------------------------------------------------------------------
module booth_div_core #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_mag_i,
  input  logic [WIDTH:0]   divisor_mag_i,
  output logic [WIDTH:0]   part_rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH:0]   dvs_o,
  output logic             last_step_o
);

  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    prem_d = prem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    // The partial remainder stays within [-|d|, |d|), so doubling it and
    // appending a bit still fits in WIDTH+1 signed bits; the dropped MSB is
    // always a copy of the new sign.
    shifted = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial   = prem_q[WIDTH] ? (shifted + dvs_q) : (shifted - dvs_q);
    if (load_i) begin
      prem_d = '0;
      quo_d  = dividend_mag_i;
      dvs_d  = divisor_mag_i;
      cnt_d  = CNT_W'(WIDTH);
    end else if (step_i) begin
      prem_d = trial;
      quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem_q <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prem_q <= prem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign part_rem_o  = prem_q;
  assign quo_o       = quo_q;
  assign dvs_o       = dvs_q;
  assign last_step_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/booth_seq_divider.sv
// ---------------------------------------------------------------------------
// booth_seq_divider
// Sequential signed divider with start/done handshake. Operands are reduced
// to magnitudes, divided by booth_div_core in WIDTH non-restoring steps, then
// sign-corrected in a FIX cycle. Results follow Verilog / and % (truncate
// toward zero, remainder takes the dividend's sign). done rises WIDTH+1
// cycles after the accepting edge for every operand pair.
//
// Ports
//   clk, rst_n     clock (rising edge) / asynchronous active-low reset
//   start          request, accepted in IDLE or DONE
//   dividend       signed dividend, sampled on the accepting edge
//   divisor        signed divisor, sampled on the accepting edge
//   quotient       signed quotient, valid while done=1
//   remainder      signed remainder, valid while done=1
//   busy           operation in progress
//   done           result valid, held until the next accepted start
//   div_by_zero    divisor was zero (quotient forced to -1, remainder=dividend)
//   overflow       only with BOOTH_DIV_OVF_EN defined: MIN / -1 was computed
// ---------------------------------------------------------------------------
module booth_seq_divider
  import booth_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
`ifdef BOOTH_DIV_OVF_EN
  output logic             overflow,
`endif
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic             div0_q, div0_d;
`ifdef BOOTH_DIV_OVF_EN
  logic             ovf_cand_q, ovf_cand_d;
  logic             overflow_q, overflow_d;
`endif

  logic             load;
  logic             step;
  logic [WIDTH:0]   dvd_ext, dvs_ext;
  logic [WIDTH:0]   dvd_mag, dvs_mag;
  logic [WIDTH:0]   core_rem;
  logic [WIDTH-1:0] core_quo;
  logic [WIDTH:0]   core_dvs;
  logic             core_last;
  logic [WIDTH:0]   rem_fixed;
  logic [WIDTH:0]   rem_signed;
  logic [WIDTH-1:0] quo_signed;
  logic             unused_bits;

  // Magnitudes are formed on WIDTH+1 bits so |MIN| is representable.
  assign dvd_ext = {dividend[WIDTH-1], dividend};
  assign dvs_ext = {divisor[WIDTH-1], divisor};
  assign dvd_mag = dividend[WIDTH-1] ? -dvd_ext : dvd_ext;
  assign dvs_mag = divisor[WIDTH-1]  ? -dvs_ext : dvs_ext;

  booth_div_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (load),
    .step_i         (step),
    .dividend_mag_i (dvd_mag[WIDTH-1:0]),
    .divisor_mag_i  (dvs_mag),
    .part_rem_o     (core_rem),
    .quo_o          (core_quo),
    .dvs_o          (core_dvs),
    .last_step_o    (core_last)
  );

  // The top bits are provably redundant: |dividend| <= 2^(WIDTH-1) and the
  // corrected remainder magnitude is below the divisor magnitude.
  assign unused_bits = ^{dvd_mag[WIDTH], rem_signed[WIDTH]};

  always_comb begin
    state_d       = state_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    busy_d        = busy_q;
    done_d        = done_q;
    div_by_zero_d = div_by_zero_q;
    dvd_neg_d     = dvd_neg_q;
    dvs_neg_d     = dvs_neg_q;
    div0_d        = div0_q;
`ifdef BOOTH_DIV_OVF_EN
    ovf_cand_d    = ovf_cand_q;
    overflow_d    = overflow_q;
`endif
    load = 1'b0;
    step = 1'b0;

    // Restore step for a negative final partial remainder, then sign fix-up.
    rem_fixed  = core_rem[WIDTH] ? (core_rem + core_dvs) : core_rem;
    rem_signed = dvd_neg_q ? -rem_fixed : rem_fixed;
    quo_signed = (dvd_neg_q ^ dvs_neg_q) ? -core_quo : core_quo;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          dvd_neg_d = dividend[WIDTH-1];
          dvs_neg_d = divisor[WIDTH-1];
          div0_d    = (divisor == '0);
`ifdef BOOTH_DIV_OVF_EN
          ovf_cand_d = (dividend == MIN_VAL) && (divisor == '1);
          overflow_d = 1'b0;
`endif
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (core_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // With a zero divisor the iteration only subtracts 0, so the partial
        // remainder ends as |dividend| and the normal sign fix reproduces the
        // dividend; only the quotient needs forcing.
        quotient_d    = div0_q ? DIV0_QUOTIENT[WIDTH-1:0] : quo_signed;
        remainder_d   = rem_signed[WIDTH-1:0];
        div_by_zero_d = div0_q;
`ifdef BOOTH_DIV_OVF_EN
        overflow_d    = ovf_cand_q;
`endif
        busy_d        = 1'b0;
        done_d        = 1'b1;
        state_d       = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      dvd_neg_q     <= 1'b0;
      dvs_neg_q     <= 1'b0;
      div0_q        <= 1'b0;
`ifdef BOOTH_DIV_OVF_EN
      ovf_cand_q    <= 1'b0;
      overflow_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      dvd_neg_q     <= dvd_neg_d;
      dvs_neg_q     <= dvs_neg_d;
      div0_q        <= div0_d;
`ifdef BOOTH_DIV_OVF_EN
      ovf_cand_q    <= ovf_cand_d;
      overflow_q    <= overflow_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
`ifdef BOOTH_DIV_OVF_EN
  assign overflow    = overflow_q;
`endif

endmodule
